// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single data port (port B) of the dual-port RAM between several
// requesters, for example the core data interface and a DMA engine. The
// arbiter is round-robin. A master can hold a bounded bus lock so that an
// atomic read-modify-write sequence is not interleaved with other traffic.
// Read data returns one cycle after an enabled read. It is routed back to the
// master that issued the read by a per-master valid strobe.
//
// Ports
//   clk          clock
//   reset        asynchronous active-high reset
//   req_i        per-master access request
//   lock_i       per-master request to keep ownership after the current grant
//   we_i         per-master byte write enables, slice i = [4i+3:4i], 0 = read
//   addr_i       per-master address, slice i = [32i+31:32i]
//   wdata_i      per-master write data, slice i = [32i+31:32i]
//   gnt_o        one-hot grant, combinational, same cycle as the request
//   rvalid_o     read data valid, one bit per master
//   rdata_o      read data shared by all masters, qualified by rvalid_o
//   mem_en_o     port enable
//   mem_we_o     port byte write enables
//   mem_addr_o   port address
//   mem_wdata_o  port write data
//   mem_rdata_i  port read data, valid one cycle after an enabled read
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int N_MASTERS = 2,
   parameter int MAX_LOCK  = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_MASTERS-1:0]      req_i,
   input  logic [N_MASTERS-1:0]      lock_i,
   input  logic [4*N_MASTERS-1:0]    we_i,
   input  logic [32*N_MASTERS-1:0]   addr_i,
   input  logic [32*N_MASTERS-1:0]   wdata_i,
   output logic [N_MASTERS-1:0]      gnt_o,
   output logic [N_MASTERS-1:0]      rvalid_o,
   output logic [31:0]               rdata_o,
   output logic                      mem_en_o,
   output logic [3:0]                mem_we_o,
   output logic [31:0]               mem_addr_o,
   output logic [31:0]               mem_wdata_o,
   input  logic [31:0]               mem_rdata_i
);

   localparam int IW = (N_MASTERS > 2) ? 2 : 1;

   typedef enum logic {
      ARB,
      LOCKED
   } state_t;

   state_t          state_r, state_n;
   logic [IW-1:0]   ptr_r, ptr_n;
   logic [IW-1:0]   owner_r, owner_n;
   logic [7:0]      lock_cnt_r, lock_cnt_n;
   logic            rd_pend_r;
   logic [IW-1:0]   rd_id_r;

   logic            arb_found;
   logic [IW-1:0]   arb_win;
   logic            any_gnt;
   logic [IW-1:0]   win;
   logic [3:0]      win_we;

   // Index of the master after i, wrapping at N_MASTERS. It is used to move
   // the round-robin pointer past the master that was just served.
   function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
      if (int'(i) == N_MASTERS - 1)
         return '0;
      else
         return i + IW'(1);
   endfunction

   // Round-robin search. Start at ptr_r and take the first requester found,
   // wrapping modulo N_MASTERS. The result is only used in the ARB state.
   always_comb begin
      int idx;
      arb_found = 1'b0;
      arb_win   = '0;
      idx       = 0;
      for (int k = 0; k < N_MASTERS; k++) begin
         idx = int'(ptr_r) + k;
         if (idx >= N_MASTERS)
            idx = idx - N_MASTERS;
         if (!arb_found && req_i[idx]) begin
            arb_found = 1'b1;
            arb_win   = IW'(idx);
         end
      end
   end

   // Grant selection and the port mux. While the port is locked, only the
   // owner can be granted and every other request is masked. With no grant,
   // all port outputs are driven to zero so that the downstream address
   // decode never sees stale values.
   always_comb begin
      any_gnt     = 1'b0;
      win         = '0;
      gnt_o       = '0;
      win_we      = '0;
      mem_en_o    = 1'b0;
      mem_we_o    = '0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      if (state_r == LOCKED) begin
         if (req_i[owner_r]) begin
            any_gnt = 1'b1;
            win     = owner_r;
         end
      end else if (arb_found) begin
         any_gnt = 1'b1;
         win     = arb_win;
      end
      if (any_gnt) begin
         gnt_o[win]  = 1'b1;
         win_we      = we_i[int'(win)*4 +: 4];
         mem_en_o    = 1'b1;
         mem_we_o    = win_we;
         mem_addr_o  = addr_i[int'(win)*32 +: 32];
         mem_wdata_o = wdata_i[int'(win)*32 +: 32];
      end
   end

   // Next-state logic for the lock FSM.
   //
   // lock_cnt_r counts the grants already given in the current lock tenure,
   // including the grant made in ARB that started the lock. The grant made
   // while lock_cnt_r == MAX_LOCK-1 is therefore the MAX_LOCK-th one, and
   // the lock is released after it. With MAX_LOCK == 1 a lock can never
   // extend past the first grant, so the LOCKED state is never entered.
   //
   // Each release points ptr_r just past the owner. A master released by the
   // timeout therefore has to wait until the others have had their turn.
   always_comb begin
      state_n    = state_r;
      ptr_n      = ptr_r;
      owner_n    = owner_r;
      lock_cnt_n = lock_cnt_r;
      case (state_r)
         ARB: begin
            if (arb_found) begin
               if (lock_i[arb_win] && (MAX_LOCK > 1)) begin
                  state_n    = LOCKED;
                  owner_n    = arb_win;
                  lock_cnt_n = 8'd1;
               end else begin
                  ptr_n = next_idx(arb_win);
               end
            end
         end
         LOCKED: begin
            if (!req_i[owner_r] || !lock_i[owner_r] ||
                (lock_cnt_r == 8'(MAX_LOCK - 1))) begin
               state_n    = ARB;
               ptr_n      = next_idx(owner_r);
               lock_cnt_n = '0;
            end else begin
               lock_cnt_n = lock_cnt_r + 8'd1;
            end
         end
         default: begin
            state_n = ARB;
         end
      endcase
   end

   // Arbiter state registers. Reset returns to ARB with the pointer at
   // master 0. It also drops any lock that is held.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= ARB;
         ptr_r      <= '0;
         owner_r    <= '0;
         lock_cnt_r <= '0;
      end else begin
         state_r    <= state_n;
         ptr_r      <= ptr_n;
         owner_r    <= owner_n;
         lock_cnt_r <= lock_cnt_n;
      end
   end

   // Remember which master issued the read accepted this cycle. The RAM
   // returns the data one cycle later, and that data is steered to the
   // master through rvalid_o. Reset discards a read that is still pending.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_pend_r <= 1'b0;
         rd_id_r   <= '0;
      end else begin
         rd_pend_r <= any_gnt && (win_we == 4'b0000);
         if (any_gnt)
            rd_id_r <= win;
      end
   end

   // Read return. rdata_o is a straight pass-through of the RAM output.
   // rvalid_o is the only qualifier the masters look at.
   always_comb begin
      rvalid_o = '0;
      if (rd_pend_r)
         rvalid_o[rd_id_r] = 1'b1;
      rdata_o = mem_rdata_i;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter with two masters and MAX_LOCK = 8.
// A small byte-writable RAM model sits behind the port. The stimulus process
// checks the combinational grant and port outputs in every cycle. Each read
// it expects to be accepted is pushed into a queue. A separate monitor pops
// that queue whenever rvalid_o is raised.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

   logic         clk;
   logic         reset;
   logic [1:0]   req_i;
   logic [1:0]   lock_i;
   logic [7:0]   we_i;
   logic [63:0]  addr_i;
   logic [63:0]  wdata_i;
   logic [1:0]   gnt_o;
   logic [1:0]   rvalid_o;
   logic [31:0]  rdata_o;
   logic         mem_en_o;
   logic [3:0]   mem_we_o;
   logic [31:0]  mem_addr_o;
   logic [31:0]  mem_wdata_o;
   logic [31:0]  mem_rdata_i;

   typedef struct {
      logic [1:0]  id;
      logic [31:0] data;
   } rd_t;

   rd_t   expQ[$];
   int    checkCount;
   int    errorCount;
   logic [31:0] ram [0:255];

   mem_port_arbiter #(
      .N_MASTERS (2),
      .MAX_LOCK  (8)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req_i       (req_i),
      .lock_i      (lock_i),
      .we_i        (we_i),
      .addr_i      (addr_i),
      .wdata_i     (wdata_i),
      .gnt_o       (gnt_o),
      .rvalid_o    (rvalid_o),
      .rdata_o     (rdata_o),
      .mem_en_o    (mem_en_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_rdata_i (mem_rdata_i)
   );

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model for port B. Writes are byte-masked, and reads are registered
   // with a latency of one cycle.
   always @(posedge clk) begin
      if (mem_en_o) begin
         if (mem_we_o != 4'b0000) begin
            for (int b = 0; b < 4; b++)
               if (mem_we_o[b])
                  ram[mem_addr_o[9:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
         end else begin
            mem_rdata_i <= ram[mem_addr_o[9:2]];
         end
      end
   end

   // Scoreboard monitor. Every rvalid_o pulse must match the oldest read
   // still waiting in the queue, both in master id and in data.
   always @(negedge clk) begin
      rd_t e;
      if (rvalid_o != 2'b00) begin
         checkCount++;
         if (expQ.size() == 0) begin
            errorCount++;
            $display("[TB] FAIL unexpected_rvalid: rvalid_o=%b rdata_o=%h, required no rvalid", rvalid_o, rdata_o);
         end else begin
            e = expQ.pop_front();
            if (rvalid_o !== e.id || rdata_o !== e.data) begin
               errorCount++;
               $display("[TB] FAIL read_return: rvalid_o=%b rdata_o=%h, required %b %h", rvalid_o, rdata_o, e.id, e.data);
            end
         end
      end
   end

   // Watchdog, so that a stuck run still ends with a report.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Drive one cycle of inputs just after the rising edge.
   task automatic applyStimulus(input logic [1:0] req, input logic [1:0] lock,
                                input logic [3:0] we0, input logic [31:0] a0, input logic [31:0] d0,
                                input logic [3:0] we1, input logic [31:0] a1, input logic [31:0] d1);
      @(posedge clk);
      #1;
      req_i   = req;
      lock_i  = lock;
      we_i    = {we1, we0};
      addr_i  = {a1, a0};
      wdata_i = {d1, d0};
   endtask

   // Compare the grant and port outputs on the falling edge.
   task automatic checkOutput(input string name, input logic [1:0] expGnt, input logic [31:0] expAddr);
      @(negedge clk);
      checkCount++;
      if (gnt_o !== expGnt || mem_en_o !== (|expGnt) || mem_addr_o !== expAddr) begin
         errorCount++;
         $display("[TB] FAIL %s: gnt_o=%b mem_en_o=%b mem_addr_o=%h, required %b %b %h",
                  name, gnt_o, mem_en_o, mem_addr_o, expGnt, |expGnt, expAddr);
      end
   endtask

   task automatic expectRead(input logic [1:0] id, input logic [31:0] data);
      rd_t e;
      e.id   = id;
      e.data = data;
      expQ.push_back(e);
   endtask

   task automatic idle();
      applyStimulus(2'b00, 2'b00, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0);
   endtask

   // Directed sequence. The comments give the expected round-robin pointer.
   initial begin
      checkCount  = 0;
      errorCount  = 0;
      mem_rdata_i = '0;
      for (int i = 0; i < 256; i++)
         ram[i] = 32'h0;
      ram[8'h40] = 32'hDEADBEEF;
      reset   = 1'b1;
      req_i   = '0;
      lock_i  = '0;
      we_i    = '0;
      addr_i  = '0;
      wdata_i = '0;

      // Reset state: no grant, no rvalid, port outputs at zero.
      checkOutput("reset_idle", 2'b00, 32'h0);
      checkCount++;
      if (rvalid_o !== 2'b00 || mem_we_o !== 4'h0 || mem_wdata_o !== 32'h0) begin
         errorCount++;
         $display("[TB] FAIL reset_outputs: rvalid_o=%b mem_we_o=%h mem_wdata_o=%h, required 0 0 0", rvalid_o, mem_we_o, mem_wdata_o);
      end
      reset = 1'b0;
      $display("[TB] reset released");

      // Single master read of 0x100 (ptr 0 -> 1).
      applyStimulus(2'b01, 2'b00, 4'h0, 32'h100, 32'h0, 4'h0, 32'h0, 32'h0);
      checkOutput("single_read_gnt", 2'b01, 32'h100);
      expectRead(2'b01, 32'hDEADBEEF);
      idle();
      checkOutput("single_read_idle", 2'b00, 32'h0);

      // Write by M0 to 0x40 (ptr stays 1), then read by M1 (ptr -> 0).
      applyStimulus(2'b01, 2'b00, 4'hF, 32'h40, 32'h12345678, 4'h0, 32'h0, 32'h0);
      checkOutput("write_gnt", 2'b01, 32'h40);
      checkCount++;
      if (mem_we_o !== 4'hF || mem_wdata_o !== 32'h12345678) begin
         errorCount++;
         $display("[TB] FAIL write_port: mem_we_o=%h mem_wdata_o=%h, required f 12345678", mem_we_o, mem_wdata_o);
      end
      applyStimulus(2'b10, 2'b00, 4'h0, 32'h0, 32'h0, 4'h0, 32'h40, 32'h0);
      checkOutput("m1_read_gnt", 2'b10, 32'h40);
      expectRead(2'b10, 32'h12345678);

      // Contention: both masters read continuously, and the grants alternate.
      for (int c = 0; c < 4; c++) begin
         applyStimulus(2'b11, 2'b00, 4'h0, 32'h100, 32'h0, 4'h0, 32'h40, 32'h0);
         if (c % 2 == 0) begin
            checkOutput("contend_m0", 2'b01, 32'h100);
            expectRead(2'b01, 32'hDEADBEEF);
         end else begin
            checkOutput("contend_m1", 2'b10, 32'h40);
            expectRead(2'b10, 32'h12345678);
         end
      end

      // Move ptr to 1 with a single M0 write.
      applyStimulus(2'b01, 2'b00, 4'hF, 32'h80, 32'hA, 4'h0, 32'h0, 32'h0);
      checkOutput("ptr_to_m1", 2'b01, 32'h80);

      // Lock: M1 locks for 3 cycles, then releases; M0 requests throughout.
      for (int c = 0; c < 4; c++) begin
         applyStimulus(2'b11, (c < 3) ? 2'b10 : 2'b00, 4'hF, 32'h80, 32'hA, 4'hF, 32'h84, 32'hB);
         checkOutput("lock_m1_held", 2'b10, 32'h84);
      end
      applyStimulus(2'b11, 2'b00, 4'hF, 32'h80, 32'hA, 4'hF, 32'h84, 32'hB);
      checkOutput("lock_after_release", 2'b01, 32'h80);

      // Move ptr to 0 with a single M1 write.
      applyStimulus(2'b10, 2'b00, 4'h0, 32'h0, 32'h0, 4'hF, 32'h84, 32'hB);
      checkOutput("ptr_to_m0", 2'b10, 32'h84);

      // Lock timeout: M0 holds lock forever. It gets 8 grants, then M1, then M0.
      for (int c = 0; c < 10; c++) begin
         applyStimulus(2'b11, 2'b01, 4'hF, 32'h80, 32'hA, 4'hF, 32'h84, 32'hB);
         if (c < 8 || c == 9)
            checkOutput("timeout_m0", 2'b01, 32'h80);
         else
            checkOutput("timeout_m1", 2'b10, 32'h84);
      end
      // The owner drops req: no grant, back to ARB with ptr at 1.
      idle();
      checkOutput("owner_drop_req", 2'b00, 32'h0);

      // M1 locks and reads twice. Reset arrives while the second read is
      // still pending.
      applyStimulus(2'b10, 2'b10, 4'h0, 32'h0, 32'h0, 4'h0, 32'h40, 32'h0);
      checkOutput("pre_reset_lock", 2'b10, 32'h40);
      expectRead(2'b10, 32'h12345678);
      applyStimulus(2'b10, 2'b10, 4'h0, 32'h0, 32'h0, 4'h0, 32'h40, 32'h0);
      checkOutput("pre_reset_locked", 2'b10, 32'h40);
      @(posedge clk);
      #1;
      reset = 1'b1;
      req_i = 2'b00;
      lock_i = 2'b00;
      checkOutput("reset_mid_lock", 2'b00, 32'h0);
      checkCount++;
      if (rvalid_o !== 2'b00) begin
         errorCount++;
         $display("[TB] FAIL reset_drop_rvalid: rvalid_o=%b, required 00", rvalid_o);
      end
      reset = 1'b0;

      // After the reset is released, M0 wins the first simultaneous request.
      applyStimulus(2'b11, 2'b00, 4'h0, 32'h100, 32'h0, 4'h0, 32'h40, 32'h0);
      checkOutput("post_reset_m0", 2'b01, 32'h100);
      expectRead(2'b01, 32'hDEADBEEF);
      idle();
      checkOutput("post_reset_idle", 2'b00, 32'h0);
      idle();
      checkOutput("final_idle", 2'b00, 32'h0);

      checkCount++;
      if (expQ.size() != 0) begin
         errorCount++;
         $display("[TB] FAIL scoreboard_drain: %0d reads outstanding, required 0", expQ.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
